// File: rtl/sha256_nonce_sched.sv
// sha256_nonce_sched: nonce issue counter, valid delay line, hash-word
// checker and a small golden-nonce FIFO for the sha256 hash pipelines.
// Optional macro SHA256_TARGET_MASK_EN adds target_mask_i; a match is then
// ((hash_w & target_mask) == 0) instead of (hash_w == 0).
module sha256_nonce_sched #(
  parameter int LATENCY    = 133,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        load_i,
  input  logic [31:0] load_nonce_i,
  input  logic        run_i,
  output logic [31:0] nonce_out_o,
  input  logic [31:0] hash_w_i,
`ifdef SHA256_TARGET_MASK_EN
  input  logic [31:0] target_mask_i,
`endif
  output logic        gn_valid_o,
  output logic [31:0] gn_data_o,
  input  logic        gn_rd_i,
  output logic        overflow_o,
  output logic        busy_o
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;

  logic [31:0]        nonce_q, nonce_d;
  logic [31:0]        check_q, check_d;
  logic [LATENCY-1:0] vd_q, vd_d;
  logic [31:0]        mem_q [FIFO_DEPTH];
  logic [AW-1:0]      rd_q, wr_q;
  logic [CW-1:0]      cnt_q;
  logic               ovf_q;

  logic issue, vd_out, match, push, pop, full, do_push, drop;

  assign issue  = run_i & ~load_i;
  assign vd_out = vd_q[LATENCY-1];

`ifdef SHA256_TARGET_MASK_EN
  assign match = ((hash_w_i & target_mask_i) == 32'h0);
`else
  assign match = (hash_w_i == 32'h0);
`endif

  // A load flushes the FIFO, so neither a push nor a pop may act in that cycle.
  assign push    = vd_out & match & ~load_i;
  assign pop     = gn_rd_i & (cnt_q != '0) & ~load_i;
  assign full    = (cnt_q == CW'(FIFO_DEPTH));
  // When full, a simultaneous pop frees the slot the push needs.
  assign do_push = push & (~full | pop);
  assign drop    = push & full & ~pop;

  // Next-state for the issue counter, the check counter and the valid delay line.
  always_comb begin
    nonce_d = nonce_q;
    check_d = check_q;
    vd_d    = {vd_q[LATENCY-2:0], issue};
    if (load_i) begin
      nonce_d = load_nonce_i;
      check_d = load_nonce_i;
      vd_d    = '0;
    end else begin
      if (run_i)  nonce_d = nonce_q + 32'd1;
      if (vd_out) check_d = check_q + 32'd1;
    end
  end

  // Issue/check counters and the delay line; reset acts as a load of nonce 0.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      nonce_q <= '0;
      check_q <= '0;
      vd_q    <= '0;
    end else begin
      nonce_q <= nonce_d;
      check_q <= check_d;
      vd_q    <= vd_d;
    end
  end

  // FIFO storage; contents are only observed through the valid-gated head.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q] <= check_q;
  end

  // FIFO pointers, occupancy and sticky overflow, all cleared by reset or load.
  always_ff @(posedge clk_i) begin
    if (reset_i || load_i) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (pop)     rd_q <= rd_q + 1'b1;
      if (do_push && !pop)      cnt_q <= cnt_q + 1'b1;
      else if (pop && !do_push) cnt_q <= cnt_q - 1'b1;
      if (drop) ovf_q <= 1'b1;
    end
  end

  assign nonce_out_o = nonce_q;
  assign gn_valid_o  = (cnt_q != '0);
  assign gn_data_o   = gn_valid_o ? mem_q[rd_q] : 32'h0;
  assign overflow_o  = ovf_q;
  assign busy_o      = |vd_q;

endmodule

// File: tb/tb_sha256_nonce_sched.sv
// Directed + randomized bench for sha256_nonce_sched with a queue-based
// reference model (in-flight nonces tagged with their check cycle).
module tb_sha256_nonce_sched;
  localparam int L = 4;
  localparam int D = 4;

  logic        clk = 1'b0;
  logic        reset, load, run, gn_rd;
  logic [31:0] load_nonce, hash_w, nonce_out, gn_data;
  logic        gn_valid, overflow, busy;
`ifdef SHA256_TARGET_MASK_EN
  logic [31:0] target_mask;
`endif

  always #5 clk = ~clk;

  sha256_nonce_sched #(.LATENCY(L), .FIFO_DEPTH(D)) dut (
    .clk_i        (clk),
    .reset_i      (reset),
    .load_i       (load),
    .load_nonce_i (load_nonce),
    .run_i        (run),
    .nonce_out_o  (nonce_out),
    .hash_w_i     (hash_w),
`ifdef SHA256_TARGET_MASK_EN
    .target_mask_i(target_mask),
`endif
    .gn_valid_o   (gn_valid),
    .gn_data_o    (gn_data),
    .gn_rd_i      (gn_rd),
    .overflow_o   (overflow),
    .busy_o       (busy)
  );

  typedef struct { logic [31:0] n; int due; } fl_t;
  fl_t         infl[$];
  logic [31:0] mq[$];
  logic [31:0] m_nonce;
  logic        m_ovf;
  logic [31:0] hist [8];
  logic [31:0] force_n;
  int          cyc, checks, failures, mode;
  bit          chk_en;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  function automatic bit m_match(input logic [31:0] h);
`ifdef SHA256_TARGET_MASK_EN
    return (h & target_mask) == 32'h0;
`else
    return h == 32'h0;
`endif
  endfunction

  // One clock cycle: drive the pipeline hash word, compare, advance the model.
  task automatic step();
    bit          full, pop, push;
    logic [31:0] pn;
    hist[cyc % 8] = nonce_out;
    case (mode)
      0:       hash_w = 32'h0;
      1:       hash_w = (cyc >= L && hist[(cyc - L) % 8] === force_n) ? 32'h0 : 32'hDEAD0001;
      2:       hash_w = ($urandom_range(0, 2) == 0) ? 32'h0 : ($urandom | 32'h1);
      default: hash_w = 32'h0000ABCD;
    endcase
    if (chk_en) begin
      chk("nonce_out", nonce_out, m_nonce);
      chk("busy", busy, infl.size() != 0);
      chk("gn_valid", gn_valid, mq.size() != 0);
      chk("overflow", overflow, m_ovf);
      if (mq.size() != 0) chk("gn_data", gn_data, mq[0]);
    end
    if (reset || load) begin
      m_nonce = reset ? 32'h0 : load_nonce;
      infl.delete();
      mq.delete();
      m_ovf = 1'b0;
    end else begin
      push = 1'b0;
      pn   = 32'h0;
      if (infl.size() != 0 && infl[0].due == cyc) begin
        push = m_match(hash_w);
        pn   = infl[0].n;
        void'(infl.pop_front());
      end
      full = (mq.size() == D);
      pop  = gn_rd && (mq.size() != 0);
      if (pop) void'(mq.pop_front());
      if (push) begin
        if (!full || pop) mq.push_back(pn);
        else m_ovf = 1'b1;
      end
      if (run) begin
        infl.push_back('{m_nonce, cyc + L});
        m_nonce = m_nonce + 32'd1;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic load_job(input logic [31:0] n);
    load = 1'b1; load_nonce = n;
    step();
    load = 1'b0;
  endtask

  task automatic run_n(input int k);
    run = 1'b1;
    repeat (k) step();
    run = 1'b0;
  endtask

  task automatic idle(input int k);
    repeat (k) step();
  endtask

  task automatic pop_chk(input string tag, input logic [31:0] exp);
    chk({tag, "_v"}, gn_valid, 1'b1);
    chk(tag, gn_data, exp);
    gn_rd = 1'b1;
    step();
    gn_rd = 1'b0;
  endtask

  initial begin
    reset = 1'b1; load = 1'b0; run = 1'b0; gn_rd = 1'b0; load_nonce = 32'h0;
    hash_w = 32'h1; force_n = 32'h0; mode = 2;
    cyc = 0; checks = 0; failures = 0; chk_en = 1'b0;
    m_nonce = 32'h0; m_ovf = 1'b0;
    for (int i = 0; i < 8; i++) hist[i] = 32'h0;
`ifdef SHA256_TARGET_MASK_EN
    target_mask = 32'hFFFFFFFF;
`endif
    step();
    chk_en = 1'b1;
    chk("rst_nonce", nonce_out, 32'h0);
    chk("rst_gn_data", gn_data, 32'h0);
    chk("rst_gn_valid", gn_valid, 1'b0);
    step();
    reset = 1'b0;

    // Single forced match on nonce 0x13, run held high through the load.
    mode = 1; force_n = 32'h13;
    run = 1'b1;
    load_job(32'h10);
    run_n(8);
    idle(L + 1);
    pop_chk("s1_head", 32'h13);
    chk("s1_empty", gn_valid, 1'b0);

    // Gapped run with every slot matching: repeated nonces must not count.
    mode = 0;
    load_job(32'h100);
    run_n(1);
    idle(2);
    chk("s2_hold", nonce_out, 32'h101);
    run_n(2);
    idle(L + 1);
    pop_chk("s2_a", 32'h100);
    pop_chk("s2_b", 32'h101);
    pop_chk("s2_c", 32'h102);
    chk("s2_empty", gn_valid, 1'b0);

    // 32-bit wrap of both issue and check counters.
    load_job(32'hFFFFFFFE);
    run_n(4);
    idle(L + 1);
    pop_chk("s3_a", 32'hFFFFFFFE);
    pop_chk("s3_b", 32'hFFFFFFFF);
    pop_chk("s3_c", 32'h00000000);
    pop_chk("s3_d", 32'h00000001);

    // Six matches with no reads, then push and pop together while full.
    load_job(32'h200);
    run_n(6);
    idle(L + 1);
    chk("s4_ovf", overflow, 1'b1);
    chk("s4_head", gn_data, 32'h200);
    run_n(1);            // issues 0x206
    idle(L - 1);
    gn_rd = 1'b1;        // pop in the cycle 0x206 is pushed
    step();
    gn_rd = 1'b0;
    chk("s4_ovf_kept", overflow, 1'b1);
    pop_chk("s4_a", 32'h201);
    pop_chk("s4_b", 32'h202);
    pop_chk("s4_c", 32'h203);
    pop_chk("s4_d", 32'h206);
    chk("s4_empty", gn_valid, 1'b0);

    // Load while matching nonces are in flight and the FIFO is full.
    load_job(32'h300);
    run_n(6);
    idle(L + 1);
    chk("s5_pre_ovf", overflow, 1'b1);
    run = 1'b1;
    idle(3);
    load_job(32'h500);   // run still high: load wins
    run = 1'b0;
    chk("s5_gn_valid", gn_valid, 1'b0);
    chk("s5_ovf", overflow, 1'b0);
    chk("s5_busy", busy, 1'b0);
    chk("s5_nonce", nonce_out, 32'h500);
    idle(L + 2);
    chk("s5_no_push", gn_valid, 1'b0);

    // Masked target: hash 0x0000ABCD matches only with the mask feature.
    mode = 3;
`ifdef SHA256_TARGET_MASK_EN
    target_mask = 32'hFFFF0000;
`endif
    load_job(32'h600);
    run_n(1);
    idle(L + 1);
`ifdef SHA256_TARGET_MASK_EN
    pop_chk("s6_mask_hit", 32'h600);
    target_mask = 32'hFFFFFFFF;
`else
    chk("s6_no_hit", gn_valid, 1'b0);
`endif

    // Randomized traffic with occasional loads and resets.
    mode = 2;
    for (int i = 0; i < 500; i++) begin
      reset      = ($urandom_range(0, 150) == 0);
      load       = ($urandom_range(0, 40) == 0);
      load_nonce = ($urandom_range(0, 1) == 0) ? 32'hFFFFFFFC : $urandom;
      run        = ($urandom_range(0, 3) != 0);
      gn_rd      = ($urandom_range(0, 2) == 0);
      step();
    end
    reset = 1'b0; load = 1'b0; run = 1'b0; gn_rd = 1'b0;
    idle(L + 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
